// File: rtl/sdp_burst_wr_port.sv
// Write-side port of a simple dual-port RAM: takes a base address, streams words into consecutive
// addresses until eot, then offers one completion token carrying the number of words written.
module sdp_burst_wr_port #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16,
  parameter int W_CNT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              addr_if_valid,
  output logic              addr_if_ready,
  input  logic [W_ADDR-1:0] addr_if_data,
  input  logic              addr_if_eot,
  input  logic              data_if_valid,
  output logic              data_if_ready,
  input  logic [W_DATA-1:0] data_if_data,
  input  logic              data_if_eot,
  output logic              done_if_valid,
  input  logic              done_if_ready,
  output logic [W_CNT-1:0]  done_if_data,
  output logic              done_if_eot,
  output logic              en_o,
  output logic [W_ADDR-1:0] addr_o,
  output logic [W_DATA-1:0] data_o
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state, state_nx;
  logic [W_ADDR-1:0] addr_reg, addr_nx;
  logic [W_CNT-1:0]  cnt_reg, cnt_nx;

  // The base-address channel carries no framing; its eot is deliberately dropped.
  logic unused_addr_eot;
  assign unused_addr_eot = addr_if_eot;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      state    <= state_nx;
      addr_reg <= addr_nx;
      cnt_reg  <= cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    addr_nx       = addr_reg;
    cnt_nx        = cnt_reg;
    addr_if_ready = 1'b0;
    data_if_ready = 1'b0;
    done_if_valid = 1'b0;
    en_o          = 1'b0;
    case (state)
      IDLE: begin
        addr_if_ready = 1'b1;
        if (addr_if_valid) begin
          addr_nx  = addr_if_data;
          cnt_nx   = '0;
          state_nx = BURST;
        end
      end
      BURST: begin
        data_if_ready = 1'b1;
        en_o          = data_if_valid;
        // The eot word is written like any other; the burst closes after it.
        if (data_if_valid) begin
          addr_nx = addr_reg + W_ADDR'(1);
          cnt_nx  = cnt_reg + W_CNT'(1);
          if (data_if_eot) state_nx = DONE;
        end
      end
      DONE: begin
        done_if_valid = 1'b1;
        if (done_if_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign addr_o       = addr_reg;
  assign data_o       = data_if_data;
  assign done_if_data = cnt_reg;
  assign done_if_eot  = 1'b0;

endmodule

// File: tb/tb_sdp_burst_wr_port.sv
// Bench for sdp_burst_wr_port: directed bursts followed by random ones, checked against an
// address/count model computed from base + index arithmetic.
module tb_sdp_burst_wr_port;

  localparam int W_DATA = 16;
  localparam int W_ADDR = 16;
  localparam int W_CNT  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              addr_if_valid = 1'b0;
  logic              addr_if_ready;
  logic [W_ADDR-1:0] addr_if_data = '0;
  logic              addr_if_eot = 1'b0;
  logic              data_if_valid = 1'b0;
  logic              data_if_ready;
  logic [W_DATA-1:0] data_if_data = '0;
  logic              data_if_eot = 1'b0;
  logic              done_if_valid;
  logic              done_if_ready = 1'b0;
  logic [W_CNT-1:0]  done_if_data;
  logic              done_if_eot;
  logic              en_o;
  logic [W_ADDR-1:0] addr_o;
  logic [W_DATA-1:0] data_o;

  int n_cmp = 0;
  int n_bad = 0;

  sdp_burst_wr_port #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_CNT(W_CNT)) dut (
    .clk(clk), .rst(rst),
    .addr_if_valid(addr_if_valid), .addr_if_ready(addr_if_ready),
    .addr_if_data(addr_if_data), .addr_if_eot(addr_if_eot),
    .data_if_valid(data_if_valid), .data_if_ready(data_if_ready),
    .data_if_data(data_if_data), .data_if_eot(data_if_eot),
    .done_if_valid(done_if_valid), .done_if_ready(done_if_ready),
    .done_if_data(done_if_data), .done_if_eot(done_if_eot),
    .en_o(en_o), .addr_o(addr_o), .data_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a base address for one cycle while IDLE.
  task automatic send_addr(input logic [W_ADDR-1:0] base);
    @(negedge clk);
    data_if_valid = 1'b0;
    data_if_eot   = 1'b0;
    addr_if_valid = 1'b1;
    addr_if_data  = base;
    addr_if_eot   = $urandom_range(0, 1) == 1;
    #1;
    chk("idle_addr_ready", addr_if_ready, 1);
    chk("idle_data_ready", data_if_ready, 0);
    chk("idle_done_valid", done_if_valid, 0);
    @(posedge clk);
  endtask

  // Stream n words (pattern from data_pat, or random when use_pat=0); a 1 in gaps[k] inserts
  // an idle cycle before word k. Expected address of word i is (base + i) mod 2**W_ADDR.
  task automatic send_words(input logic [W_ADDR-1:0] base, input int n, input bit with_eot,
                            input logic [31:0] gaps, input bit use_pat,
                            input logic [W_DATA-1:0] pat0);
    int i = 0;
    int k = 0;
    logic [W_DATA-1:0] w;
    logic [W_ADDR-1:0] exp_addr;
    while (i < n && k < 64) begin
      @(negedge clk);
      addr_if_valid = $urandom_range(0, 1) == 1;   // must be ignored outside IDLE
      addr_if_data  = W_ADDR'($urandom);
      if (k < 32 && gaps[k]) begin
        data_if_valid = 1'b0;
        data_if_eot   = $urandom_range(0, 1) == 1;
        data_if_data  = W_DATA'($urandom);
        #1;
        chk("gap_en", en_o, 0);
        chk("gap_data_ready", data_if_ready, 1);
      end else begin
        w = use_pat ? pat0 + W_DATA'(i) : W_DATA'($urandom);
        data_if_valid = 1'b1;
        data_if_data  = w;
        data_if_eot   = with_eot && (i == n - 1);
        exp_addr      = W_ADDR'(32'(base) + i);
        #1;
        chk("burst_en", en_o, 1);
        chk("burst_addr", addr_o, exp_addr);
        chk("burst_data", data_o, w);
        chk("burst_addr_ready", addr_if_ready, 0);
        i++;
      end
      k++;
      @(posedge clk);
    end
  endtask

  // Hold done_if.ready low for 'hold' cycles, then accept the token and confirm return to IDLE.
  task automatic finish_done(input int n, input int hold);
    logic [W_CNT-1:0] exp_cnt = W_CNT'(n);
    @(negedge clk);
    addr_if_valid = 1'b0;
    data_if_valid = 1'b1;
    data_if_eot   = 1'b1;
    done_if_ready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      if (h == hold) done_if_ready = 1'b1;
      #1;
      chk("done_valid", done_if_valid, 1);
      chk("done_count", done_if_data, exp_cnt);
      chk("done_eot", done_if_eot, 0);
      chk("done_en", en_o, 0);
      chk("done_data_ready", data_if_ready, 0);
      chk("done_addr_ready", addr_if_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    done_if_ready = 1'b0;
    data_if_valid = 1'b0;
    data_if_eot   = 1'b0;
    #1;
    chk("back_idle_done_valid", done_if_valid, 0);
    chk("back_idle_addr_ready", addr_if_ready, 1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    addr_if_valid = 1'b0;
    data_if_valid = 1'b0;
    done_if_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_en", en_o, 0);
    chk("rst_done_valid", done_if_valid, 0);
    chk("rst_addr_ready", addr_if_ready, 1);
    chk("rst_data_ready", data_if_ready, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [W_ADDR-1:0] rb;
    int rn;
    int rh;

    // Reset held 3 cycles
    do_reset(3);

    // Three back-to-back words at base 0x0010
    send_addr(16'h0010);
    send_words(16'h0010, 3, 1'b1, 32'h0, 1'b1, 16'h00A1);
    finish_done(3, 0);

    // Address wrap across 0xFFFF
    send_addr(16'hFFFE);
    send_words(16'hFFFE, 4, 1'b1, 32'h0, 1'b0, '0);
    finish_done(4, 1);

    // Valid toggling, done held off 5 cycles
    send_addr(16'h0300);
    send_words(16'h0300, 2, 1'b1, 32'b0010, 1'b0, '0);
    finish_done(2, 5);

    // Single-word burst
    send_addr(16'h0100);
    send_words(16'h0100, 1, 1'b1, 32'h0, 1'b1, 16'hBEEF);
    finish_done(1, 0);

    // Reset after 2 of 5 words, then a fresh burst whose count restarts
    send_addr(16'h0020);
    send_words(16'h0020, 2, 1'b0, 32'h0, 1'b0, '0);
    do_reset(2);
    send_addr(16'h0040);
    send_words(16'h0040, 3, 1'b1, 32'h0, 1'b0, '0);
    finish_done(3, 0);

    // Random bursts
    for (int b = 0; b < 25; b++) begin
      rb = W_ADDR'($urandom);
      rn = $urandom_range(1, 10);
      rh = $urandom_range(0, 3);
      send_addr(rb);
      send_words(rb, rn, 1'b1, $urandom & 32'h0000_5A5A, 1'b0, '0);
      finish_done(rn, rh);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
